// File: rtl/dmux_2x32_buf.sv
// dmux_2x32_buf: routes one input word per cycle to one of two output
// ports, each backed by its own small FIFO so a stalled consumer does not
// block words already queued for the other port.
//
// Handshake: a transfer happens on a rising clk edge exactly when the
// sender's valid and the receiver's ready are both 1 in that cycle.
// - Input side: the producer drives in_valid/a/s, and this block drives
//   in_ready. in_ready depends only on s and the registered occupancy
//   counts, never on r0/r1, so a full FIFO never passes a word through.
// - Output side: this block drives vk/yk, and the consumer drives rk.
//   yk reads as 0 whenever vk is 0.
// - A word accepted at an edge is visible on yk in the following cycle.
//   There is no same-cycle bypass.
module dmux_2x32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [WIDTH-1:0]         a,
    input  logic                     s,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         y0,
    output logic                     v0,
    input  logic                     r0,
    output logic [WIDTH-1:0]         y1,
    output logic                     v1,
    input  logic                     r1,
    output logic [$clog2(DEPTH):0]   cnt0,
    output logic [$clog2(DEPTH):0]   cnt1,
    output logic                     busy
);

    // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];

    logic [AW-1:0] wp0, rp0, wp1, rp1;
    logic          push0, push1, pop0, pop1;
    logic          full0, full1;

    // Full flags come straight from the registered counts.
    always_comb begin
        full0 = (cnt0 == CW'(DEPTH));
        full1 = (cnt1 == CW'(DEPTH));
    end

    // Accept decision and per-port push/pop strobes.
    always_comb begin
        in_ready = s ? !full1 : !full0;
        push0    = in_valid && in_ready && !s;
        push1    = in_valid && in_ready &&  s;
        pop0     = v0 && r0;
        pop1     = v1 && r1;
    end

    // Storage arrays. They need no reset because every read is masked by
    // the reset-cleared counts.
    always_ff @(posedge clk) begin
        if (push0) mem0[wp0] <= a;
        if (push1) mem1[wp1] <= a;
    end

    // Port-0 pointers and occupancy. Reset discards all queued words.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp0  <= '0;
            rp0  <= '0;
            cnt0 <= '0;
        end else begin
            if (push0) wp0 <= wp0 + AW'(1);
            if (pop0)  rp0 <= rp0 + AW'(1);
            cnt0 <= cnt0 + CW'(push0) - CW'(pop0);
        end
    end

    // Port-1 pointers and occupancy. Reset discards all queued words.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp1  <= '0;
            rp1  <= '0;
            cnt1 <= '0;
        end else begin
            if (push1) wp1 <= wp1 + AW'(1);
            if (pop1)  rp1 <= rp1 + AW'(1);
            cnt1 <= cnt1 + CW'(push1) - CW'(pop1);
        end
    end

    // Head outputs. Every output is derived from registered state, so busy
    // and the valids do not glitch.
    always_comb begin
        v0   = (cnt0 != '0);
        v1   = (cnt1 != '0);
        y0   = v0 ? mem0[rp0] : '0;
        y1   = v1 ? mem1[rp1] : '0;
        busy = v0 | v1;
    end

endmodule

// File: tb/tb_dmux_2x32_buf.sv
// Testbench for dmux_2x32_buf.
// The bench checks a table of fixed vectors, then hand-written reset and
// wrap-around sequences, then random traffic compared against a
// queue-based reference model.
module tb_dmux_2x32_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic clrn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] a;
    logic             s, in_valid, in_ready;
    logic [WIDTH-1:0] y0, y1;
    logic             v0, v1, r0, r1;
    logic [CW-1:0]    cnt0, cnt1;
    logic             busy;

    dmux_2x32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn), .a(a), .s(s), .in_valid(in_valid),
        .in_ready(in_ready), .y0(y0), .v0(v0), .r0(r0),
        .y1(y1), .v1(v1), .r1(r1), .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] log1[$];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // All outputs must read as the reset/empty state.
    task automatic reset_chk(input string tag);
        chk({tag, "_v0"}, WIDTH'(v0), 0);
        chk({tag, "_v1"}, WIDTH'(v1), 0);
        chk({tag, "_y0"}, y0, 0);
        chk({tag, "_y1"}, y1, 0);
        chk({tag, "_cnt0"}, WIDTH'(cnt0), 0);
        chk({tag, "_cnt1"}, WIDTH'(cnt1), 0);
        chk({tag, "_busy"}, WIDTH'(busy), 0);
        chk({tag, "_rdy"}, WIDTH'(in_ready), 1);
    endtask

    // ---------------- driver + reference model ----------------
    // Drives one cycle, checks outputs against the queue model, then
    // advances the model by the transfers that happen on the edge.
    task automatic step(input string tag, input logic iv, input logic is,
                        input logic [WIDTH-1:0] ia, input logic ir0, input logic ir1);
        logic exp_rdy, acc, p0, p1;
        in_valid = iv; s = is; a = ia; r0 = ir0; r1 = ir1;
        #1;
        exp_rdy = ((is ? q1.size() : q0.size()) != DEPTH);
        chk({tag, "_v0"}, WIDTH'(v0), WIDTH'(q0.size() != 0));
        chk({tag, "_y0"}, y0, (q0.size() != 0) ? q0[0] : '0);
        chk({tag, "_v1"}, WIDTH'(v1), WIDTH'(q1.size() != 0));
        chk({tag, "_y1"}, y1, (q1.size() != 0) ? q1[0] : '0);
        chk({tag, "_cnt0"}, WIDTH'(cnt0), WIDTH'(q0.size()));
        chk({tag, "_cnt1"}, WIDTH'(cnt1), WIDTH'(q1.size()));
        chk({tag, "_busy"}, WIDTH'(busy), WIDTH'(q0.size() + q1.size() != 0));
        chk({tag, "_rdy"}, WIDTH'(in_ready), WIDTH'(exp_rdy));
        acc = iv && exp_rdy;
        p0  = (q0.size() != 0) && ir0;
        p1  = (q1.size() != 0) && ir1;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) begin
            log1.push_back(q1[0]);
            void'(q1.pop_front());
        end
        if (acc) begin
            if (is) q1.push_back(ia);
            else    q0.push_back(ia);
        end
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             iv;
        logic             s;
        logic [WIDTH-1:0] a;
        logic             r0;
        logic             r1;
        logic             ev0;
        logic [WIDTH-1:0] ey0;
        logic             ev1;
        logic [WIDTH-1:0] ey1;
        logic [CW-1:0]    ec0;
        logic [CW-1:0]    ec1;
        logic             erdy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int idx;
        logic r1_t;

        // iv  s     a              r0    r1  | v0   y0              v1   y1              c0    c1    rdy
        tbl[0]  = '{1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0, 2'd0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,        2'd1, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222, 2'd0, 2'd1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'hA0,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'hA1,       1'b0, 1'b1, 1'b1, 32'hA0,       1'b0, 32'h0,        2'd1, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'hA2,       1'b0, 1'b1, 1'b1, 32'hA0,       1'b0, 32'h0,        2'd2, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'hB0,       1'b0, 1'b0, 1'b1, 32'hA0,       1'b0, 32'h0,        2'd2, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'hA2,       1'b1, 1'b0, 1'b1, 32'hA0,       1'b1, 32'hB0,       2'd2, 2'd1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'hA2,       1'b1, 1'b0, 1'b1, 32'hA1,       1'b1, 32'hB0,       2'd1, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA2,       1'b1, 32'hB0,       2'd1, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0, 2'd0, 1'b1};

        // Reset applied mid-cycle must clear outputs with no clock edge.
        clrn = 1'b1; in_valid = 1'b0; s = 1'b0; a = '0; r0 = 1'b0; r1 = 1'b0;
        #2 clrn = 1'b0;
        #1 reset_chk("rst_idle");
        @(negedge clk);
        clrn = 1'b1;

        // Table vectors: push/pop latency, back-pressure, full pop+push.
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].iv; s = tbl[i].s; a = tbl[i].a;
            r0 = tbl[i].r0; r1 = tbl[i].r1;
            #1;
            chk($sformatf("tbl%0d_v0", i), WIDTH'(v0), WIDTH'(tbl[i].ev0));
            chk($sformatf("tbl%0d_y0", i), y0, tbl[i].ey0);
            chk($sformatf("tbl%0d_v1", i), WIDTH'(v1), WIDTH'(tbl[i].ev1));
            chk($sformatf("tbl%0d_y1", i), y1, tbl[i].ey1);
            chk($sformatf("tbl%0d_cnt0", i), WIDTH'(cnt0), WIDTH'(tbl[i].ec0));
            chk($sformatf("tbl%0d_cnt1", i), WIDTH'(cnt1), WIDTH'(tbl[i].ec1));
            chk($sformatf("tbl%0d_busy", i), WIDTH'(busy),
                WIDTH'((tbl[i].ec0 != 0) || (tbl[i].ec1 != 0)));
            chk($sformatf("tbl%0d_rdy", i), WIDTH'(in_ready), WIDTH'(tbl[i].erdy));
            @(posedge clk);
            @(negedge clk);
        end

        // Reset mid-operation: fill cnt0=2, cnt1=1, then reset.
        step("fill0", 1'b1, 1'b0, 32'h0000_0C01, 1'b0, 1'b0);
        step("fill1", 1'b1, 1'b0, 32'h0000_0C02, 1'b0, 1'b0);
        step("fill2", 1'b1, 1'b1, 32'h0000_0C03, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_cnt0", WIDTH'(cnt0), 2);
        chk("pre_rst_cnt1", WIDTH'(cnt1), 1);
        #1 clrn = 1'b0;
        #1 reset_chk("rst_mid");
        q0.delete();
        q1.delete();
        @(negedge clk);
        clrn = 1'b1;
        step("post_rst_push", 1'b1, 1'b0, 32'h5, 1'b0, 1'b0);
        step("post_rst_head", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_y0", y0, 0);

        // Wrap-around on port 1 with r1 toggling 1,0,1,...
        log1.delete();
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx == 6 && q1.size() == 0) break;
            r1_t = (cyc % 2 == 0);
            if (idx < 6 && q1.size() != DEPTH) begin
                step($sformatf("wrap%0d", cyc), 1'b1, 1'b1, WIDTH'(idx + 1), 1'b0, r1_t);
                idx++;
            end else begin
                step($sformatf("wrap%0d", cyc), idx < 6, 1'b1, WIDTH'(idx + 1), 1'b0, r1_t);
            end
        end
        chk("wrap_count", WIDTH'(log1.size()), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("wrap_order%0d", k), (k < log1.size()) ? log1[k] : '1, WIDTH'(k + 1));

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($sformatf("rnd%0d", n), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
        end

        // Drain and confirm idle.
        for (int n = 0; n < 8; n++) step($sformatf("drain%0d", n), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("final_busy", WIDTH'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
